tag_lookup_sequencer: RTL and testbench

//  Sequences the tag lookup of one L2 set. Steps through every way of the indexed set, reading the
//  tag array one way per cycle and feeding one shared tag comparator. Returns hit/miss, the hit way,
//  and a victim way on miss. Sits between the L2 request front-end and the tag array.

---
 rtl/l2_cache_pkg.sv | 21 ++
 rtl/way_tag_compare.sv | 16 +
 rtl/tag_lookup_sequencer.sv | 178 +++++++++++++++++
 tb/tb_tag_lookup_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared L2 cache definitions: geometry, way/tag/index types and the
// tag-lookup sequencer state encoding.
package l2_cache_pkg;

    localparam int ADDR_SIZE  = 32;
    localparam int TAG_BITS   = 12;
    localparam int INDEX_BITS = 14;
    localparam int WAYS       = 8;
    localparam int WAY_BITS   = $clog2(WAYS);

    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [INDEX_BITS-1:0] index_t;
    typedef logic [WAY_BITS-1:0]   way_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/way_tag_compare.sv
// Single shared tag comparator: a way matches when its line is valid and its
// stored tag equals the tag latched from the request.
module way_tag_compare
    import l2_cache_pkg::*;
#(
    parameter int TAG_BITS = l2_cache_pkg::TAG_BITS
) (
    input  logic [TAG_BITS-1:0] lat_tag_i,
    input  logic [TAG_BITS-1:0] rd_tag_i,
    input  logic                rd_vld_i,
    output logic                match_o
);

    assign match_o = rd_vld_i && (rd_tag_i == lat_tag_i);

endmodule

// File: rtl/tag_lookup_sequencer.sv
// Walks every way of one L2 set through a single tag comparator and reports hit way or victim way.
// Optional TAG_LOOKUP_EARLY_EXIT_EN: stop scanning at the first match (resp_multi_o then tied to 0).
module tag_lookup_sequencer #(
    parameter int ADDR_SIZE  = l2_cache_pkg::ADDR_SIZE,
    parameter int TAG_BITS   = l2_cache_pkg::TAG_BITS,
    parameter int INDEX_BITS = l2_cache_pkg::INDEX_BITS,
    parameter int WAYS       = l2_cache_pkg::WAYS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [ADDR_SIZE-1:0]     req_addr_i,
    output logic                     tag_rd_en_o,
    output logic [INDEX_BITS-1:0]    tag_rd_set_o,
    output logic [$clog2(WAYS)-1:0]  tag_rd_way_o,
    input  logic [TAG_BITS-1:0]      tag_rd_tag_i,
    input  logic                     tag_rd_vld_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic                     resp_hit_o,
    output logic [$clog2(WAYS)-1:0]  resp_way_o,
    output logic                     resp_multi_o
);
    import l2_cache_pkg::*;

    localparam int WAY_BITS = $clog2(WAYS);
    localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(WAYS - 1);

    state_e                state_q, state_d;
    logic [TAG_BITS-1:0]   tag_q, tag_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic [WAY_BITS-1:0]   rd_way_q, rd_way_d;
    logic [WAY_BITS-1:0]   cmp_way_q, cmp_way_d;
    logic [WAY_BITS-1:0]   hit_way_q, hit_way_d;
    logic [WAY_BITS-1:0]   inv_way_q, inv_way_d;
    logic [WAY_BITS-1:0]   rr_q, rr_d;
    logic                  rd_done_q, rd_done_d;
    logic                  cmp_vld_q, cmp_vld_d;
    logic                  hit_q, hit_d;
    logic                  multi_q, multi_d;
    logic                  inv_q, inv_d;
    logic                  match;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr_i[ADDR_SIZE-TAG_BITS-INDEX_BITS-1:0];

    way_tag_compare #(.TAG_BITS(TAG_BITS)) u_cmp (
        .lat_tag_i (tag_q),
        .rd_tag_i  (tag_rd_tag_i),
        .rd_vld_i  (tag_rd_vld_i),
        .match_o   (match)
    );

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        rd_way_d     = rd_way_q;
        cmp_way_d    = cmp_way_q;
        hit_way_d    = hit_way_q;
        inv_way_d    = inv_way_q;
        rr_d         = rr_q;
        rd_done_d    = rd_done_q;
        cmp_vld_d    = cmp_vld_q;
        hit_d        = hit_q;
        multi_d      = multi_q;
        inv_d        = inv_q;
        req_ready_o  = 1'b0;
        tag_rd_en_o  = 1'b0;
        tag_rd_set_o = '0;
        tag_rd_way_o = '0;
        resp_valid_o = 1'b0;
        resp_hit_o   = 1'b0;
        resp_way_o   = '0;
        resp_multi_o = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    tag_d     = req_addr_i[ADDR_SIZE-1 -: TAG_BITS];
                    idx_d     = req_addr_i[ADDR_SIZE-TAG_BITS-1 -: INDEX_BITS];
                    hit_d     = 1'b0;
                    multi_d   = 1'b0;
                    inv_d     = 1'b0;
                    rd_way_d  = '0;
                    rd_done_d = 1'b0;
                    cmp_vld_d = 1'b0;
                    state_d   = SCAN;
                end
            end

            SCAN: begin
                tag_rd_set_o = idx_q;
                // Issue the read for this cycle; its data is compared next cycle.
                cmp_vld_d = !rd_done_q;
                if (!rd_done_q) begin
                    tag_rd_en_o  = 1'b1;
                    tag_rd_way_o = rd_way_q;
                    cmp_way_d    = rd_way_q;
                    rd_way_d     = rd_way_q + 1'b1;
                    rd_done_d    = (rd_way_q == LAST_WAY);
                end
                if (cmp_vld_q) begin
                    if (match) begin
                        if (!hit_q) begin
                            hit_d     = 1'b1;
                            hit_way_d = cmp_way_q;
                        end else begin
                            multi_d = 1'b1;
                        end
                    end
                    if (!tag_rd_vld_i && !inv_q) begin
                        inv_d     = 1'b1;
                        inv_way_d = cmp_way_q;
                    end
                end
                if (rd_done_q) state_d = RESP;
`ifdef TAG_LOOKUP_EARLY_EXIT_EN
                // The read issued this cycle is left to die; RESP ignores its data.
                if (cmp_vld_q && match) state_d = RESP;
`endif
            end

            RESP: begin
                resp_valid_o = 1'b1;
                resp_hit_o   = hit_q;
                resp_way_o   = hit_q ? hit_way_q : (inv_q ? inv_way_q : rr_q);
`ifdef TAG_LOOKUP_EARLY_EXIT_EN
                resp_multi_o = 1'b0;
`else
                resp_multi_o = multi_q;
`endif
                if (resp_ready_i) begin
                    state_d = IDLE;
                    // Round-robin victim only advances when it was actually used.
                    if (!hit_q && !inv_q) rr_d = rr_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tag_q     <= '0;
            idx_q     <= '0;
            rd_way_q  <= '0;
            cmp_way_q <= '0;
            hit_way_q <= '0;
            inv_way_q <= '0;
            rr_q      <= '0;
            rd_done_q <= 1'b0;
            cmp_vld_q <= 1'b0;
            hit_q     <= 1'b0;
            multi_q   <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            idx_q     <= idx_d;
            rd_way_q  <= rd_way_d;
            cmp_way_q <= cmp_way_d;
            hit_way_q <= hit_way_d;
            inv_way_q <= inv_way_d;
            rr_q      <= rr_d;
            rd_done_q <= rd_done_d;
            cmp_vld_q <= cmp_vld_d;
            hit_q     <= hit_d;
            multi_q   <= multi_d;
            inv_q     <= inv_d;
        end
    end

endmodule

// File: tb/tb_tag_lookup_sequencer.sv
// Bench for tag_lookup_sequencer (WAYS=4): a tag-array responder, a per-cycle
// reference model of the lookup, directed corner cases and randomized lookups.
module tb_tag_lookup_sequencer;
    localparam int AW = 32, TB = 12, IB = 14, W = 4, WB = 2;
`ifdef TAG_LOOKUP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_valid = 1'b0, req_ready;
    logic [AW-1:0] req_addr = '0;
    logic          tag_rd_en;
    logic [IB-1:0] tag_rd_set;
    logic [WB-1:0] tag_rd_way;
    logic [TB-1:0] tag_rd_tag = '0;
    logic          tag_rd_vld = 1'b0;
    logic          resp_valid, resp_ready = 1'b1, resp_hit, resp_multi;
    logic [WB-1:0] resp_way;

    always #5 clk = ~clk;

    tag_lookup_sequencer #(.ADDR_SIZE(AW), .TAG_BITS(TB), .INDEX_BITS(IB), .WAYS(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .tag_rd_en_o(tag_rd_en), .tag_rd_set_o(tag_rd_set), .tag_rd_way_o(tag_rd_way),
        .tag_rd_tag_i(tag_rd_tag), .tag_rd_vld_i(tag_rd_vld),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit),
        .resp_way_o(resp_way), .resp_multi_o(resp_multi)
    );

    // Tag array contents for the set under test; answers one cycle after a read, junk otherwise.
    logic [TB-1:0] mem_tag [W];
    logic          mem_vld [W];
    bit            pend = 1'b0;
    int            pway = 0;
    always @(negedge clk) begin
        pend = tag_rd_en;
        pway = int'(tag_rd_way);
    end
    always @(posedge clk) begin
        #1;
        if (pend) begin
            tag_rd_tag = mem_tag[pway];
            tag_rd_vld = mem_vld[pway];
        end else begin
            tag_rd_tag = TB'($urandom);
            tag_rd_vld = 1'($urandom);
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state
    bit            busy = 1'b0, seen_rv = 1'b0;
    int            acc = 0, lat = 0, rr = 0, nresp = 0, first_n = 0;
    logic [TB-1:0] m_tag;
    logic [IB-1:0] m_idx;
    bit            m_hit, m_multi, m_inv;
    int            m_way;
    bit            last_hit, last_multi;
    int            last_way;

    task automatic model_accept(input logic [AW-1:0] a);
        int nm, first, inv;
        m_tag = a[AW-1 -: TB];
        m_idx = a[AW-TB-1 -: IB];
        nm = 0; first = -1; inv = -1;
        for (int w = 0; w < W; w++) begin
            if (mem_vld[w] && mem_tag[w] == m_tag) begin
                if (first < 0) first = w;
                nm++;
            end
            if (!mem_vld[w] && inv < 0) inv = w;
        end
        m_hit   = (nm > 0);
        m_inv   = (inv >= 0);
        m_multi = !EE && (nm > 1);
        m_way   = m_hit ? first : (m_inv ? inv : rr);
        lat     = (EE && m_hit) ? first + 3 : W + 2;
    endtask

    always @(negedge clk) begin
        int  n;
        bit  rv, en, scan;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 1);
            chk("rst_rd_en", tag_rd_en, 0);
            chk("rst_rd_set", tag_rd_set, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_fields", {resp_hit, resp_multi, resp_way}, 0);
            busy = 1'b0;
            rr   = 0;
        end else if (busy) begin
            n    = cyc - acc;
            scan = (n >= 1) && (n < lat);
            en   = scan && (n <= W);
            rv   = (n >= lat);
            chk("req_ready_busy", req_ready, 0);
            chk("tag_rd_en", tag_rd_en, en);
            if (en) chk("tag_rd_way", tag_rd_way, n - 1);
            chk("tag_rd_set", tag_rd_set, scan ? m_idx : 0);
            chk("resp_valid", resp_valid, rv);
            if (rv) begin
                chk("resp_hit", resp_hit, m_hit);
                chk("resp_way", resp_way, m_way);
                chk("resp_multi", resp_multi, m_multi);
                if (!seen_rv && resp_valid) begin
                    seen_rv = 1'b1;
                    first_n = n;
                end
                if (resp_ready) begin
                    last_hit = resp_hit; last_way = int'(resp_way); last_multi = resp_multi;
                    if (!m_hit && !m_inv) rr = (rr + 1) % W;
                    nresp++;
                    busy = 1'b0;
                end
            end
        end else begin
            chk("req_ready_idle", req_ready, 1);
            chk("rd_en_idle", tag_rd_en, 0);
            chk("rd_set_idle", tag_rd_set, 0);
            chk("resp_valid_idle", resp_valid, 0);
            if (req_valid) begin
                model_accept(req_addr);
                busy = 1'b1; acc = cyc; seen_rv = 1'b0; first_n = -1;
            end
        end
        cyc++;
    end

    function automatic logic [AW-1:0] mk(input logic [TB-1:0] t, input logic [IB-1:0] i);
        return {t, i, 6'($urandom)};
    endfunction

    task automatic set_mem(input logic [TB-1:0] t0, t1, t2, t3, input logic [3:0] v);
        mem_tag[0] = t0; mem_tag[1] = t1; mem_tag[2] = t2; mem_tag[3] = t3;
        for (int w = 0; w < W; w++) mem_vld[w] = v[w];
    endtask

    task automatic issue(input logic [AW-1:0] a);
        int t = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = a;
        do begin @(negedge clk); t++; end while (!req_ready && t < 50);
        if (!req_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = AW'($urandom);
    endtask

    task automatic wait_resp(input int start, input bit rnd);
        int t = 0;
        while (nresp == start && t < 100) begin
            @(posedge clk); #1;
            if (rnd) resp_ready = ($urandom_range(0, 2) != 0);
            t++;
        end
        if (nresp == start) chk("resp_timeout", 0, 1);
        resp_ready = 1'b1;
    endtask

    task automatic run_req(input logic [AW-1:0] a, input bit rnd);
        int s = nresp;
        issue(a);
        wait_resp(s, rnd);
    endtask

    initial begin
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int s, t;
        set_mem(12'h111, 12'h222, 12'hABC, 12'h333, 4'hF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hit in way 2
        run_req(mk(12'hABC, 14'h1234), 1'b0);
        chk("hit2_hit", last_hit, 1);
        chk("hit2_way", last_way, 2);
        chk("hit2_latency", first_n, EE ? 5 : 6);

        // Miss with an invalid way: victim is that way, rr_ptr untouched
        set_mem(12'h111, 12'h222, 12'hABC, 12'h333, 4'b1101);
        run_req(mk(12'h555, 14'h0042), 1'b0);
        chk("missinv_hit", last_hit, 0);
        chk("missinv_way", last_way, 1);
        chk("missinv_rr", rr, 0);

        // Back-to-back all-valid misses walk the round-robin pointer
        set_mem(12'h111, 12'h222, 12'hABC, 12'h333, 4'hF);
        for (int i = 0; i < 5; i++) begin
            run_req(mk(12'h777, IB'(i)), 1'b0);
            chk("rr_way", last_way, exp_seq[i]);
        end

        // Duplicate valid tags in ways 1 and 3
        set_mem(12'h111, 12'hABC, 12'h222, 12'hABC, 4'hF);
        run_req(mk(12'hABC, 14'h3FFF), 1'b0);
        chk("multi_way", last_way, 1);
        chk("multi_flag", last_multi, EE ? 0 : 1);

        // Backpressure: response held for 10 cycles with nothing else moving
        set_mem(12'h111, 12'h222, 12'h333, 12'h444, 4'hF);
        resp_ready = 1'b0;
        s = nresp;
        issue(mk(12'h444, 14'h0101));
        t = 0;
        do begin @(negedge clk); t++; end while (!resp_valid && t < 30);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_hit", resp_hit, 1);
            chk("bp_way", resp_way, 3);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rd_en", tag_rd_en, 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        wait_resp(s, 1'b0);

        // Reset in the middle of a scan abandons the lookup
        set_mem(12'h111, 12'h222, 12'h333, 12'h444, 4'hF);
        issue(mk(12'h999, 14'h0202));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rd_en", tag_rd_en, 0);
        chk("rstmid_req_ready", req_ready, 1);
        chk("rstmid_resp_valid", resp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        s = nresp;
        repeat (15) @(posedge clk);
        chk("rstmid_no_resp", nresp, s);
        run_req(mk(12'h999, 14'h0303), 1'b0);
        chk("rstmid_rr_cleared", last_way, 0);

        // Randomized lookups over a small tag alphabet to provoke hits, multi-hits and misses
        for (int i = 0; i < 150; i++) begin
            for (int w = 0; w < W; w++) begin
                mem_tag[w] = TB'($urandom_range(0, 3));
                mem_vld[w] = ($urandom_range(0, 3) != 0);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_req(mk(TB'($urandom_range(0, 3)), IB'($urandom)), 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
